// File: rtl/i2c_reg_access.sv
// i2c_reg_access: register-level front end for the byte-level I2C master.
// Turns one register read/write request into a single master transaction,
// checks the request length, times out a hung master, re-packs read data
// and returns one status response per request.
// Optional build macro: I2C_REG_ACCESS_RETRY_EN (retry on address NAK with backoff).
//
// Handshakes: a transfer happens on a request or response channel in the cycle
// where valid && ready are both high at the rising clk edge; valid, once high,
// holds its payload stable until that edge.
module i2c_reg_access #(
   parameter int MAX_DATA_BYTES = 2,
   parameter int XFER_W         = $clog2(MAX_DATA_BYTES + 2),
   parameter int LEN_W          = $clog2(MAX_DATA_BYTES + 1),
   parameter int TIMEOUT_CYCLES = 65535
`ifdef I2C_REG_ACCESS_RETRY_EN
   ,
   parameter int RETRY_COUNT    = 3,
   parameter int BACKOFF_CYCLES = 1024
`endif
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic                            req_write,
   input  logic [6:0]                      req_dev_addr,
   input  logic [7:0]                      req_reg_addr,
   input  logic [LEN_W-1:0]                req_len,
   input  logic [8*MAX_DATA_BYTES-1:0]     req_wdata,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [1:0]                      rsp_status,
   output logic [8*MAX_DATA_BYTES-1:0]     rsp_rdata,
   output logic [6:0]                      m_i2c_address,
   output logic [8*(MAX_DATA_BYTES+1)-1:0] m_write_data,
   input  logic [8*(MAX_DATA_BYTES+1)-1:0] m_read_data,
   output logic                            m_start,
   output logic [XFER_W-1:0]               m_write_transfer_length,
   output logic [XFER_W-1:0]               m_read_transfer_length,
   input  logic                            m_busy,
   input  logic                            m_complete,
   input  logic                            m_no_response,
   input  logic [XFER_W-1:0]               m_total_read,
   output logic [2:0]                      o_dbg_state
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_NACK    = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_BADLEN  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_EVAL    = 3'd4,
      S_RESP    = 3'd5
`ifdef I2C_REG_ACCESS_RETRY_EN
      ,
      S_BACKOFF = 3'd6
`endif
   } state_t;

   state_t                            r_state;
   state_t                            w_next;
   logic                              r_armed;
   logic                              r_write;
   logic [6:0]                        r_dev;
   logic [7:0]                        r_reg;
   logic [LEN_W-1:0]                  r_len;
   logic [8*MAX_DATA_BYTES-1:0]       r_wdata;
   logic [TO_W-1:0]                   r_to_cnt;
   logic [1:0]                        r_status;
   logic [8*MAX_DATA_BYTES-1:0]       r_rdata;
   logic [6:0]                        r_m_addr;
   logic [8*(MAX_DATA_BYTES+1)-1:0]   r_m_wdata;
   logic [XFER_W-1:0]                 r_m_wlen;
   logic [XFER_W-1:0]                 r_m_rlen;

   logic                              w_handshake;
   logic                              w_badlen;
   logic                              w_timeout;
   logic                              w_eval_ok;
   logic                              w_retry;
   logic [8*MAX_DATA_BYTES-1:0]       w_eval_rdata;
   logic [8*(MAX_DATA_BYTES+1)-1:0]   w_m_wdata;

`ifdef I2C_REG_ACCESS_RETRY_EN
   localparam int AT_W = $clog2(RETRY_COUNT + 1);
   localparam int BO_W = $clog2(BACKOFF_CYCLES + 1);
   logic [AT_W-1:0] r_attempt;
   logic [BO_W-1:0] r_bo_cnt;
   logic            w_bo_done;
   assign w_bo_done = (r_bo_cnt >= BO_W'(BACKOFF_CYCLES - 1));
   assign w_retry   = m_no_response && (r_attempt < AT_W'(RETRY_COUNT));
`else
   assign w_retry   = 1'b0;
`endif

   // r_armed keeps req_ready low while in reset and for the first cycle after it
   assign req_ready   = (r_state == S_IDLE) && !m_busy && r_armed;
   assign w_handshake = req_valid && req_ready;
   assign rsp_valid   = (r_state == S_RESP);
   assign m_start     = (r_state == S_ISSUE);
   assign rsp_status  = r_status;
   assign rsp_rdata   = r_rdata;
   assign m_i2c_address           = r_m_addr;
   assign m_write_data            = r_m_wdata;
   assign m_write_transfer_length = r_m_wlen;
   assign m_read_transfer_length  = r_m_rlen;
   assign o_dbg_state = r_state;

   assign w_badlen  = (r_len > LEN_W'(MAX_DATA_BYTES)) || (!r_write && (r_len == '0));
   assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Master write buffer: register address first, then the valid write data bytes
   always_comb begin
      w_m_wdata      = '0;
      w_m_wdata[7:0] = r_reg;
      for (int i = 0; i < MAX_DATA_BYTES; i++) begin
         if (r_write && (i < int'(r_len)))
            w_m_wdata[8*(i+1) +: 8] = r_wdata[8*i +: 8];
      end
   end

   // Completion verdict and byte-reversed, masked read data
   always_comb begin
      w_eval_ok    = 1'b0;
      w_eval_rdata = '0;
      if (m_no_response)
         w_eval_ok = 1'b0;
      else if (r_write)
         w_eval_ok = m_complete;
      else
         w_eval_ok = (m_total_read == XFER_W'(r_len));
      if (w_eval_ok && !r_write) begin
         for (int k = 0; k < MAX_DATA_BYTES; k++) begin
            if (k < int'(r_len))
               w_eval_rdata[8*k +: 8] = m_read_data[8*(int'(r_len) - 1 - k) +: 8];
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_handshake) w_next = S_CHECK;
         S_CHECK: w_next = w_badlen ? S_RESP : S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT: begin
            if (!m_busy)        w_next = S_EVAL;
            else if (w_timeout) w_next = S_RESP;
         end
`ifdef I2C_REG_ACCESS_RETRY_EN
         S_EVAL:    w_next = w_retry ? S_BACKOFF : S_RESP;
         S_BACKOFF: if (w_bo_done && !m_busy) w_next = S_ISSUE;
`else
         S_EVAL:    w_next = S_RESP;
`endif
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Request capture, master inputs, timeout counter and response payload
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_armed   <= 1'b0;
         r_write   <= 1'b0;
         r_dev     <= '0;
         r_reg     <= '0;
         r_len     <= '0;
         r_wdata   <= '0;
         r_to_cnt  <= '0;
         r_status  <= '0;
         r_rdata   <= '0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
         r_m_wlen  <= '0;
         r_m_rlen  <= '0;
`ifdef I2C_REG_ACCESS_RETRY_EN
         r_attempt <= '0;
         r_bo_cnt  <= '0;
`endif
      end else begin
         r_armed <= 1'b1;
         case (r_state)
            S_IDLE: begin
`ifdef I2C_REG_ACCESS_RETRY_EN
               r_attempt <= '0;
`endif
               if (w_handshake) begin
                  r_write <= req_write;
                  r_dev   <= req_dev_addr;
                  r_reg   <= req_reg_addr;
                  r_len   <= req_len;
                  r_wdata <= req_wdata;
               end
            end
            S_CHECK: begin
               if (w_badlen) begin
                  r_status <= ST_BADLEN;
                  r_rdata  <= '0;
               end else begin
                  r_m_addr  <= r_dev;
                  r_m_wdata <= w_m_wdata;
                  r_m_wlen  <= r_write ? (XFER_W'(r_len) + XFER_W'(1)) : XFER_W'(1);
                  r_m_rlen  <= r_write ? '0 : XFER_W'(r_len);
               end
            end
            S_ISSUE: r_to_cnt <= '0;
            S_WAIT: begin
               if (m_busy) begin
                  if (w_timeout) begin
                     r_status <= ST_TIMEOUT;
                     r_rdata  <= '0;
                  end else begin
                     r_to_cnt <= r_to_cnt + TO_W'(1);
                  end
               end
            end
            S_EVAL: begin
               r_status <= w_eval_ok ? ST_OK : ST_NACK;
               r_rdata  <= w_eval_rdata;
`ifdef I2C_REG_ACCESS_RETRY_EN
               if (w_retry) begin
                  r_attempt <= r_attempt + AT_W'(1);
                  r_bo_cnt  <= '0;
               end
`endif
            end
`ifdef I2C_REG_ACCESS_RETRY_EN
            S_BACKOFF: if (!w_bo_done) r_bo_cnt <= r_bo_cnt + BO_W'(1);
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_reg_access.sv
// Bench for i2c_reg_access: directed requests against a small I2C master model.
// Expected master launches and responses are queued when a request is issued;
// two monitors pop and compare as the DUT presents them.
module tb_i2c_reg_access;

   localparam int MDB = 2;
   localparam int XW  = 2;
   localparam int LW  = 2;
`ifdef I2C_REG_ACCESS_RETRY_EN
   localparam int N_ATT = 4;
`else
   localparam int N_ATT = 1;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                   req_valid, req_ready, req_write;
   logic [6:0]             req_dev_addr;
   logic [7:0]             req_reg_addr;
   logic [LW-1:0]          req_len;
   logic [8*MDB-1:0]       req_wdata;
   logic                   rsp_valid, rsp_ready;
   logic [1:0]             rsp_status;
   logic [8*MDB-1:0]       rsp_rdata;
   logic [6:0]             m_i2c_address;
   logic [8*(MDB+1)-1:0]   m_write_data, m_read_data;
   logic                   m_start, m_busy, m_complete, m_no_response;
   logic [XW-1:0]          m_write_transfer_length, m_read_transfer_length, m_total_read;
   logic [2:0]             o_dbg_state;

   i2c_reg_access dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr),
      .req_len(req_len), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
      .m_i2c_address(m_i2c_address), .m_write_data(m_write_data),
      .m_read_data(m_read_data), .m_start(m_start),
      .m_write_transfer_length(m_write_transfer_length),
      .m_read_transfer_length(m_read_transfer_length),
      .m_busy(m_busy), .m_complete(m_complete), .m_no_response(m_no_response),
      .m_total_read(m_total_read), .o_dbg_state(o_dbg_state)
   );

   // ---------------- master model ----------------
   // mode 0: complete, 1: no response, 2: hang until mdl_release, 3: ends without complete
   int   mdl_mode    = 0;
   int   mdl_delay   = 3;
   logic mdl_release = 1'b0;
   int   mdl_cnt;
   logic mdl_prev_start;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_complete <= 1'b0; m_no_response <= 1'b0;
         mdl_prev_start <= 1'b0; mdl_cnt <= 0;
      end else begin
         mdl_prev_start <= m_start;
         if (m_start && !mdl_prev_start) begin
            m_busy <= 1'b1; m_complete <= 1'b0; m_no_response <= 1'b0;
            mdl_cnt <= mdl_delay;
         end else if (m_busy) begin
            if (mdl_mode == 2) begin
               if (mdl_release) m_busy <= 1'b0;
            end else if (mdl_cnt == 0) begin
               m_busy <= 1'b0;
               m_complete <= (mdl_mode == 0);
               m_no_response <= (mdl_mode == 1);
            end else begin
               mdl_cnt <= mdl_cnt - 1;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   int start_count = 0;
   logic [34:0] exp_mst_q[$];
   logic [17:0] exp_rsp_q[$];
   logic mon_prev_start = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=bound_expired required=event", name);
   endtask

   // master launch monitor
   always @(negedge clk) begin
      if (m_start && !mon_prev_start) begin
         start_count++;
         if (exp_mst_q.size() == 0) fail_bound("unexpected_m_start");
         else chk("master_inputs",
                  {m_i2c_address, m_write_data, m_write_transfer_length, m_read_transfer_length},
                  exp_mst_q.pop_front());
      end
      mon_prev_start = m_start;
   end

   // response monitor
   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) begin
         if (exp_rsp_q.size() == 0) fail_bound("unexpected_response");
         else chk("response", {rsp_status, rsp_rdata}, exp_rsp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_req(input logic w, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [LW-1:0] len, input logic [8*MDB-1:0] wd);
      int n = 0;
      @(negedge clk);
      while (!req_ready) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            fail_bound("req_ready_wait");
            return;
         end
      end
      req_write = w; req_dev_addr = dev; req_reg_addr = ra; req_len = len; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (exp_rsp_q.size() != 0 || exp_mst_q.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > budget) begin
            fail_bound("transaction_wait");
            exp_rsp_q.delete();
            exp_mst_q.delete();
            return;
         end
      end
   endtask

   task automatic push_mst(input logic [6:0] a, input logic [23:0] wd,
                           input logic [1:0] wl, input logic [1:0] rl);
      exp_mst_q.push_back({a, wd, wl, rl});
   endtask

   // ---------------- stimulus ----------------
   int sc;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_dev_addr = '0; req_reg_addr = '0;
      req_len = '0; req_wdata = '0; rsp_ready = 1'b1; m_read_data = '0; m_total_read = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {req_ready, rsp_valid, rsp_status, rsp_rdata, m_start, m_i2c_address,
          m_write_data, m_write_transfer_length, m_read_transfer_length}, 64'd0);
      chk("reset_state", o_dbg_state, 3'd0);
      rst = 1'b0;

      // write len 2
      push_mst(7'h50, 24'hBEEF10, 2'd3, 2'd0);
      exp_rsp_q.push_back({2'b00, 16'h0000});
      sc = start_count;
      do_req(1'b1, 7'h50, 8'h10, 2'd2, 16'hBEEF);
      wait_done(200);
      chk("write_one_start", start_count - sc, 1);

      // read len 2, upper master byte stale
      m_read_data = 24'hAA1234; m_total_read = 2'd2;
      push_mst(7'h50, 24'h000020, 2'd1, 2'd2);
      exp_rsp_q.push_back({2'b00, 16'h3412});
      do_req(1'b0, 7'h50, 8'h20, 2'd2, 16'h0);
      wait_done(200);

      // read len 1, upper bytes masked
      m_read_data = 24'hAAAA5C; m_total_read = 2'd1;
      push_mst(7'h21, 24'h000033, 2'd1, 2'd1);
      exp_rsp_q.push_back({2'b00, 16'h005C});
      do_req(1'b0, 7'h21, 8'h33, 2'd1, 16'h0);
      wait_done(200);

      // write len 1, second wdata byte ignored
      push_mst(7'h11, 24'h00C344, 2'd2, 2'd0);
      exp_rsp_q.push_back({2'b00, 16'h0000});
      do_req(1'b1, 7'h11, 8'h44, 2'd1, 16'h77C3);
      wait_done(200);

      // address NAK on a read
      mdl_mode = 1;
      for (int i = 0; i < N_ATT; i++) push_mst(7'h2A, 24'h000001, 2'd1, 2'd1);
      exp_rsp_q.push_back({2'b01, 16'h0000});
      sc = start_count;
      do_req(1'b0, 7'h2A, 8'h01, 2'd1, 16'h0);
      wait_done(10000);
      chk("nack_start_count", start_count - sc, N_ATT);

      // write finishing without m_complete
      mdl_mode = 3;
      push_mst(7'h12, 24'h556602, 2'd3, 2'd0);
      exp_rsp_q.push_back({2'b01, 16'h0000});
      do_req(1'b1, 7'h12, 8'h02, 2'd2, 16'h5566);
      wait_done(200);
      mdl_mode = 0;

      // read with short total_read
      m_read_data = 24'h00ABCD; m_total_read = 2'd1;
      push_mst(7'h13, 24'h000003, 2'd1, 2'd2);
      exp_rsp_q.push_back({2'b01, 16'h0000});
      do_req(1'b0, 7'h13, 8'h03, 2'd2, 16'h0);
      wait_done(200);

      // BADLEN: read len 0, read len 3, write len 3
      sc = start_count;
      exp_rsp_q.push_back({2'b11, 16'h0000});
      do_req(1'b0, 7'h50, 8'h20, 2'd0, 16'h0);
      @(negedge clk); @(negedge clk);
      chk("badlen_rd0_latency", rsp_valid, 1'b1);
      wait_done(50);
      exp_rsp_q.push_back({2'b11, 16'h0000});
      do_req(1'b0, 7'h50, 8'h20, 2'd3, 16'h0);
      @(negedge clk); @(negedge clk);
      chk("badlen_rd3_latency", rsp_valid, 1'b1);
      wait_done(50);
      exp_rsp_q.push_back({2'b11, 16'h0000});
      do_req(1'b1, 7'h50, 8'h20, 2'd3, 16'hFFFF);
      wait_done(50);
      chk("badlen_no_start", start_count - sc, 0);

      // write len 0 sets the register pointer
      push_mst(7'h50, 24'h00005A, 2'd1, 2'd0);
      exp_rsp_q.push_back({2'b00, 16'h0000});
      do_req(1'b1, 7'h50, 8'h5A, 2'd0, 16'h1234);
      wait_done(200);

      // response held while rsp_ready low
      rsp_ready = 1'b0;
      m_read_data = 24'h11BBCC; m_total_read = 2'd2;
      push_mst(7'h40, 24'h000077, 2'd1, 2'd2);
      exp_rsp_q.push_back({2'b00, 16'hCCBB});
      do_req(1'b0, 7'h40, 8'h77, 2'd2, 16'h0);
      begin
         int n = 0;
         while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
         if (!rsp_valid) fail_bound("stall_rsp_valid_wait");
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_hold", {rsp_valid, rsp_status, rsp_rdata}, {1'b1, 2'b00, 16'hCCBB});
      end
      rsp_ready = 1'b1;
      wait_done(50);

      // reset while waiting on the master
      mdl_delay = 40;
      push_mst(7'h50, 24'h000020, 2'd1, 2'd2);
      do_req(1'b0, 7'h50, 8'h20, 2'd2, 16'h0);
      repeat (3) @(negedge clk);
      chk("in_wait_state", o_dbg_state, 3'd3);
      rst = 1'b1;
      #1;
      chk("midop_reset_outputs", {req_ready, rsp_valid, rsp_status, rsp_rdata, m_start,
          m_i2c_address, m_write_data, m_write_transfer_length, m_read_transfer_length}, 64'd0);
      exp_rsp_q.delete();
      exp_mst_q.delete();
      @(negedge clk);
      rst = 1'b0;
      mdl_delay = 3;
      push_mst(7'h50, 24'hBEEF10, 2'd3, 2'd0);
      exp_rsp_q.push_back({2'b00, 16'h0000});
      do_req(1'b1, 7'h50, 8'h10, 2'd2, 16'hBEEF);
      wait_done(200);

      // hung master: timeout, then req_ready held low until m_busy falls
      mdl_mode = 2;
      push_mst(7'h55, 24'h009966, 2'd2, 2'd0);
      exp_rsp_q.push_back({2'b10, 16'h0000});
      do_req(1'b1, 7'h55, 8'h66, 2'd1, 16'h0099);
      wait_done(70000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("ready_low_while_busy", req_ready, 1'b0);
      end
      mdl_release = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("ready_after_busy_drop", {m_busy, req_ready}, 2'b01);
      mdl_release = 1'b0;
      mdl_mode = 0;

      repeat (3) @(negedge clk);
      chk("queues_drained", exp_rsp_q.size() + exp_mst_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
